regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, giving registers per bank.
REQ-002 SHALL have parameter CNT_W, default 2, giving the width of each per-register pending counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports rd_fmode1/rd_fmode2  input  1  read bank select per port (0 int, 1 float).
REQ-006 SHALL have ports rd_addr1/rd_addr2  input  5  read register number per port.
REQ-007 SHALL have ports rd_data1/rd_data2  output  32  read data per port.
REQ-008 SHALL have ports rd_busy1/rd_busy2  output  1  addressed register has an outstanding producer.
REQ-009 SHALL have ports issue_valid  input  1, issue_fmode  input  1, issue_rd  input  5  destination claim from decode.
REQ-010 SHALL have port issue_ready  output  1  claim accepted this cycle.
REQ-011 SHALL have ports wb_valid  input  1, wb_fmode  input  1, wb_rd  input  5, wb_data  input  32  writeback.
REQ-012 SHALL have port err_underflow  output  1  sticky flag: writeback to a register with no pending claim.

Function
REQ-013 SHALL hold two banks, int and float, of NREG x 32-bit registers, plus one CNT_W-bit pending counter per register.
REQ-014 Read ports SHALL be combinational: rd_dataN = bank[rd_fmodeN][rd_addrN].
REQ-015 Write bypass: if wb_valid and (wb_fmode, wb_rd) equals (rd_fmodeN, rd_addrN), rd_dataN SHALL equal wb_data in the same cycle.
REQ-016 Int r0 SHALL read as 0, ignore writes, never count claims, and never report busy; float f0 is an ordinary register.
REQ-017 rd_busyN SHALL be 1 iff the addressed counter is nonzero after applying this cycle's writeback decrement (a same-cycle writeback clears busy when count is 1).
REQ-018 issue_ready SHALL be 0 iff the counter of (issue_fmode, issue_rd) is at its maximum, 2^CNT_W-1, and no same-cycle writeback targets that register; otherwise 1.
REQ-019 A claim is accepted when issue_valid and issue_ready; an accepted claim SHALL increment the target counter on the next edge.
REQ-020 issue_valid with issue_ready=0 SHALL change no state.
REQ-021 wb_valid SHALL write wb_data to the target register on the next edge and decrement its counter if nonzero.
REQ-022 On an accepted claim and a writeback to the same register in the same cycle, the counter SHALL be unchanged and the data SHALL be written.
REQ-023 A writeback to a register whose counter is 0 SHALL write the data, leave the counter at 0, and set err_underflow; r0 is exempt.
REQ-024 Claims and writebacks to different registers in the same cycle SHALL both take effect independently.

Reset
REQ-025 While rstn=0 at an edge, all registers, all counters, and err_underflow SHALL be cleared, and issue/wb inputs SHALL be ignored.
REQ-026 After reset: rd_data* SHALL be 0 (bypass excepted), rd_busy* 0, issue_ready 1, err_underflow 0.
REQ-027 Reset mid-operation SHALL discard all pending claims, with no partial write.

Structure
REQ-028 NREG, CNT_W, and the bank-select encoding SHALL reside in the shared CPU package alongside the instruction-set constants.
REQ-029 A sub-module regfile_bank SHALL implement one 32-bit register array with two read ports, one write port, and bypass; it is instantiated twice, with int instance zeroing r0.
REQ-030 Counters and the ready/busy logic SHALL stay in regfile_scoreboard.

Verification
REQ-031 Reset, then read int r5 and float f5 -> both 0; busy 0; issue_ready 1.
REQ-032 Claim int r3; 2 cycles later wb r3=0xDEADBEEF while reading r3 -> rd_data=0xDEADBEEF same cycle, busy 1 before the wb cycle, 0 after it.
REQ-033 Claim float f7 three times -> fourth claim sees issue_ready=0, counter stays 3; same-cycle claim+wb of f7 -> issue_ready=1, counter stays 3.
REQ-034 wb int r0=0x1234 and claim r0 -> reads 0, busy 0, err_underflow 0; wb int r9 with no claim -> r9 written, err_underflow=1 until reset.
REQ-035 Claim int r4 and float f4 in sequence -> only the selected bank reports busy; wb int r4 clears int busy only.
REQ-036 Assert rstn=0 with 2 pending claims and a concurrent wb -> after reset all counters 0, written register still 0.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU package: instruction-set constants plus the register-file
// geometry and bank-select encoding used by decode, issue and writeback.
package regfile_scoreboard_pkg;

    // Instruction-set constants (major opcodes used by decode)
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;

    // Register-file geometry
    localparam int RF_NREG  = 32;
    localparam int RF_CNT_W = 2;

    // Bank-select encoding carried on every *_fmode signal
    localparam logic FMODE_INT = 1'b0;
    localparam logic FMODE_FLT = 1'b1;

    // Int r0 is hardwired: never stored, never claimed, never busy.
    function automatic logic is_int_r0(input logic fmode, input logic [4:0] addr);
        return (fmode == FMODE_INT) && (addr == 5'd0);
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// One bank of NREG x 32-bit registers: two combinational read ports with
// write-through bypass, one write port, synchronous active-low clear.
// Ports: clk, rstn; we/waddr/wdata write port; raddr1/raddr2 -> rdata1/rdata2.
// ZERO_R0 makes register 0 read as zero and drop writes (int bank).
module regfile_bank #(
    parameter int NREG    = 32,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [NREG-1:0][31:0] mem_q, mem_d;
    logic                  r0_1, r0_2, wr_ok;

    assign wr_ok = we && !(ZERO_R0 && waddr == 5'd0);
    assign r0_1  = ZERO_R0 && raddr1 == 5'd0;
    assign r0_2  = ZERO_R0 && raddr2 == 5'd0;

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    // Bypass makes a same-cycle writeback visible to readers immediately.
    assign rdata1 = r0_1 ? 32'd0 : (wr_ok && waddr == raddr1) ? wdata : mem_q[raddr1];
    assign rdata2 = r0_2 ? 32'd0 : (wr_ok && waddr == raddr2) ? wdata : mem_q[raddr2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Int/float register file with a per-register pending-producer counter.
// Ports: clk, rstn (sync, active-low); two read ports (rd_fmodeN, rd_addrN ->
// rd_dataN, rd_busyN); issue claim (issue_valid/fmode/rd -> issue_ready);
// writeback (wb_valid/fmode/rd/data); sticky err_underflow.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREG  = RF_NREG,
    parameter int CNT_W = RF_CNT_W
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rd_fmode1,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data1,
    output logic        rd_busy1,
    input  logic        rd_fmode2,
    input  logic [4:0]  rd_addr2,
    output logic [31:0] rd_data2,
    output logic        rd_busy2,
    input  logic        issue_valid,
    input  logic        issue_fmode,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic        wb_fmode,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        err_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0][NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic                            same_tgt, claim, wb_cnt;
    logic [CNT_W-1:0]                cnt_iss, cnt_wb, cnt_rd1, cnt_rd2;
    logic [31:0]                     int_d1, int_d2, flt_d1, flt_d2;

    assign cnt_iss = cnt_q[issue_fmode][issue_rd];
    assign cnt_wb  = cnt_q[wb_fmode][wb_rd];
    assign cnt_rd1 = cnt_q[rd_fmode1][rd_addr1];
    assign cnt_rd2 = cnt_q[rd_fmode2][rd_addr2];

    assign same_tgt = wb_valid && wb_fmode == issue_fmode && wb_rd == issue_rd;
    // A writeback to a saturated register frees a slot in the same cycle.
    assign issue_ready = !(cnt_iss == CNT_MAX && !same_tgt);
    assign claim  = issue_valid && issue_ready && !is_int_r0(issue_fmode, issue_rd);
    assign wb_cnt = wb_valid && !is_int_r0(wb_fmode, wb_rd);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (claim && wb_cnt && same_tgt) begin
            // Claim and retire cancel; counter holds.
            if (cnt_wb == '0) err_d = 1'b1;
        end else begin
            if (claim) cnt_d[issue_fmode][issue_rd] = cnt_iss + 1'b1;
            if (wb_cnt) begin
                if (cnt_wb != '0) cnt_d[wb_fmode][wb_rd] = cnt_wb - 1'b1;
                else              err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;

    // Busy reflects the count after this cycle's retire: a count of 1 being
    // written back right now is already free. Int r0 count is always 0.
    assign rd_busy1 = (cnt_rd1 != '0) &&
                      !(cnt_rd1 == 1 && wb_cnt && wb_fmode == rd_fmode1 && wb_rd == rd_addr1);
    assign rd_busy2 = (cnt_rd2 != '0) &&
                      !(cnt_rd2 == 1 && wb_cnt && wb_fmode == rd_fmode2 && wb_rd == rd_addr2);

    regfile_bank #(.NREG(NREG), .ZERO_R0(1'b1)) u_int_bank (
        .clk(clk), .rstn(rstn),
        .we(wb_valid && wb_fmode == FMODE_INT), .waddr(wb_rd), .wdata(wb_data),
        .raddr1(rd_addr1), .raddr2(rd_addr2), .rdata1(int_d1), .rdata2(int_d2)
    );

    regfile_bank #(.NREG(NREG), .ZERO_R0(1'b0)) u_flt_bank (
        .clk(clk), .rstn(rstn),
        .we(wb_valid && wb_fmode == FMODE_FLT), .waddr(wb_rd), .wdata(wb_data),
        .raddr1(rd_addr1), .raddr2(rd_addr2), .rdata1(flt_d1), .rdata2(flt_d2)
    );

    assign rd_data1 = (rd_fmode1 == FMODE_FLT) ? flt_d1 : int_d1;
    assign rd_data2 = (rd_fmode2 == FMODE_FLT) ? flt_d2 : int_d2;

endmodule
